// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and types shared by the FIFO read-side blocks.
//   DEF_DATA_W : default RAM word / output data width
//   DEF_CNT_W  : default width of the delivered-word counter
//   BUF_DEPTH  : number of entries in the read-stage holding buffer
//   occ_t      : holding-buffer occupancy (0..BUF_DEPTH)
package fifo_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned BUF_DEPTH  = 2;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_read_stage_if.sv
// fifo_read_stage_if: bundles the upstream FIFO/RAM side and the downstream
// valid/ready side of the read stage.
//   fifo_empty : upstream FIFO empty flag
//   fifo_rd    : pop request to the FIFO controller
//   ram_rdata  : synchronous RAM read data (one cycle after the pop edge)
//   out_data   : downstream data word
//   out_valid  : out_data holds a word
//   out_ready  : downstream accept
//   words_out  : count of completed downstream transfers
// Modports: master = the read stage, slave = its surroundings.
interface fifo_read_stage_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
);

  logic              fifo_empty;
  logic              fifo_rd;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  words_out;

  modport master (
    input  fifo_empty,
    input  ram_rdata,
    input  out_ready,
    output fifo_rd,
    output out_data,
    output out_valid,
    output words_out
  );

  modport slave (
    output fifo_empty,
    output ram_rdata,
    output out_ready,
    input  fifo_rd,
    input  out_data,
    input  out_valid,
    input  words_out
  );

endinterface

// File: rtl/fifo_read_stage.sv
// fifo_read_stage: turns a FIFO controller plus synchronous RAM (one cycle of
// read latency) into a registered valid/ready stream. A 2-entry holding buffer
// absorbs the in-flight read so the stream runs at one word per cycle without
// ever dropping a word when the consumer stalls.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : fifo_read_stage_if.master (FIFO pop side, RAM data, output stream)
module fifo_read_stage
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  fifo_read_stage_if.master bus
);

  occ_t              r_count;
  logic              r_inflight;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [CNT_W-1:0]  r_words_out;

  occ_t              w_count_d;
  logic [DATA_W-1:0] w_head_d;
  logic [DATA_W-1:0] w_tail_d;
  logic              w_pop;
  logic              w_land;
  logic              w_rd;
  logic [2:0]        w_level;
  occ_t              w_keep;

  assign w_pop  = (r_count != '0) && bus.out_ready;
  assign w_land = r_inflight;

  // Occupancy a new read would see once it lands: words held plus the word
  // already in flight, minus the one leaving on this edge.
  assign w_level = {1'b0, r_count} + 3'(r_inflight) - 3'(w_pop);
  // Gated by reset so no pop reaches the FIFO controller while it is held.
  assign w_rd    = reset && !bus.fifo_empty && (w_level < 3'(BUF_DEPTH));

  // Words left in the buffer after this edge's pop, before any landing.
  assign w_keep = r_count - occ_t'(w_pop);

  always_comb begin
    w_count_d = r_count + occ_t'(w_land) - occ_t'(w_pop);
    w_head_d  = r_head;
    w_tail_d  = r_tail;
    if (w_pop) begin
      w_head_d = r_tail;
    end
    if (w_land) begin
      if (w_keep == '0) begin
        w_head_d = bus.ram_rdata;
      end else begin
        w_tail_d = bus.ram_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      r_inflight  <= 1'b0;
      r_head      <= '0;
      r_tail      <= '0;
      r_words_out <= '0;
    end else begin
      r_count     <= w_count_d;
      r_inflight  <= w_rd;
      r_head      <= w_head_d;
      r_tail      <= w_tail_d;
      r_words_out <= r_words_out + CNT_W'(w_pop);
    end
  end

  assign bus.fifo_rd   = w_rd;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = r_head;
  assign bus.words_out = r_words_out;

endmodule

// File: tb/tb_fifo_read_stage.sv
module tb_fifo_read_stage;

  logic clk = 1'b0;
  logic reset = 1'b0;

  fifo_read_stage_if #(.DATA_W(8), .CNT_W(4)) bus ();

  fifo_read_stage #(.DATA_W(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Upstream model: FIFO controller + synchronous RAM
  logic [7:0] mem [0:31];
  int         rd_ptr;
  int         n_words = 0;

  assign bus.fifo_empty = (rd_ptr >= n_words);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr        <= 0;
      bus.ram_rdata <= 8'h00;
    end else if (bus.fifo_rd) begin
      bus.ram_rdata <= mem[rd_ptr[4:0]];
      rd_ptr        <= rd_ptr + 1;
    end else begin
      bus.ram_rdata <= 8'hEE;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reset, preload the FIFO, check reset outputs, release on a falling edge.
  task automatic do_reset(input int load, input logic [7:0] base, input logic [7:0] step);
    @(negedge clk);
    reset          = 1'b0;
    bus.out_ready  = 1'b0;
    n_words        = load;
    for (int k = 0; k < 32; k++) mem[k] = 8'(base + k * step);
    #1;
    check("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_words", 32'(bus.words_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    int         load;   // -1: continue; else reset and preload this many words
    logic [7:0] base;
    logic [7:0] step;
    logic       rdy;
    logic       exp_rd;
    logic       exp_valid;
    logic       chk_data;
    logic [7:0] exp_data;
    logic [3:0] exp_words;
  } vec_t;

  function automatic vec_t mk(input int load, input logic [7:0] base, input logic [7:0] step,
                              input logic rdy, input logic rd, input logic vld,
                              input logic chk, input logic [7:0] data, input logic [3:0] words);
    vec_t v;
    v.load = load; v.base = base; v.step = step; v.rdy = rdy; v.exp_rd = rd;
    v.exp_valid = vld; v.chk_data = chk; v.exp_data = data; v.exp_words = words;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int         idx;
    int         pops;
    logic [7:0] exp_word;

    bus.out_ready = 1'b0;

    // 3 words, always ready: reads in cycles 0-2, data from cycle 2
    vecs.push_back(mk( 3, 8'h11, 8'h11, 1, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 1, 1, 1, 1, 8'h11, 0));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 1, 0, 1, 1, 8'h22, 1));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 1, 0, 1, 1, 8'h33, 2));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 3));
    // 5 words, stalled: two reads only, head held; ready pulls a third read
    vecs.push_back(mk( 5, 8'hA0, 8'h01, 0, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 0, 0, 1, 1, 8'hA0, 0));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 0, 0, 1, 1, 8'hA0, 0));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 0, 0, 1, 1, 8'hA0, 0));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 0, 0, 1, 1, 8'hA0, 0));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 1, 1, 1, 1, 8'hA0, 0));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 0, 0, 1, 1, 8'hA1, 1));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 0, 0, 1, 1, 8'hA1, 1));
    // FIFO empty throughout
    vecs.push_back(mk( 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(-1, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0));

    foreach (vecs[i]) begin
      if (vecs[i].load >= 0) do_reset(vecs[i].load, vecs[i].base, vecs[i].step);
      bus.out_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_fifo_rd", i), 32'(bus.fifo_rd), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_words", i), 32'(bus.words_out), 32'(vecs[i].exp_words));
      @(posedge clk);
      @(negedge clk);
    end

    // 8 words, ready toggling 1,0,1,0: in order, no duplicates
    do_reset(8, 8'h50, 8'h03);
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      bus.out_ready = (c % 2 == 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        exp_word = 8'(8'h50 + idx * 3);
        check($sformatf("toggle_word%0d", idx), 32'(bus.out_data), 32'(exp_word));
        idx++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("toggle_count", 32'(idx), 32'd8);
    check("toggle_words_out", 32'(bus.words_out), 32'd8);
    check("toggle_drained", 32'(bus.out_valid), 32'd0);

    // Reset mid-operation: word held at output plus one read in flight
    do_reset(3, 8'h11, 8'h11);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1;
    check("midrst_pre_valid", 32'(bus.out_valid), 32'd1);
    check("midrst_pre_data", 32'(bus.out_data), 32'h11);
    reset   = 1'b0;
    n_words = 0;  // controller shares the reset, so it comes back empty
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_data", 32'(bus.out_data), 32'd0);
    check("midrst_words", 32'(bus.words_out), 32'd0);
    check("midrst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
    @(negedge clk);
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("midrst_stale%0d", c), 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    check("midrst_words_after", 32'(bus.words_out), 32'd0);

    // Counter wrap at CNT_W=4: 17 transfers -> 15, 0, 1
    do_reset(17, 8'h40, 8'h01);
    bus.out_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      check($sformatf("wrap_words_c%0d", c), 32'(bus.words_out), 32'(pops % 16));
      if (bus.out_valid) begin
        check($sformatf("wrap_data%0d", pops), 32'(bus.out_data), 32'(8'(8'h40 + pops)));
        pops++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("wrap_pops", 32'(pops), 32'd17);
    check("wrap_final", 32'(bus.words_out), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_read_stage.md
FIFO_READ_STAGE -- requirements
Module: fifo_read_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of the FIFO RAM data word and output data.
REQ-002 SHALL have parameter CNT_W, default 16: width of the delivered-word statistics counter.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: the reset; asynchronous, active-low (0 = reset asserted).
REQ-005 SHALL have port fifo_empty, input, 1: the empty flag from the upstream FIFO controller.
REQ-006 SHALL have port fifo_rd, output, 1: the read/pop request to the FIFO controller; it advances the read pointer at the same edge.
REQ-007 SHALL have port ram_rdata, input, DATA_W: the synchronous RAM output; valid exactly 1 cycle after the edge that sampled fifo_rd=1.
REQ-008 SHALL have port out_data, output, DATA_W: the downstream data, taken from the head of the buffer.
REQ-009 SHALL have port out_valid, output, 1: asserted when out_data holds a word.
REQ-010 SHALL have port out_ready, input, 1: downstream accept; a transfer occurs on an edge where out_valid=1 and out_ready=1.
REQ-011 SHALL have port words_out, output, CNT_W: the count of completed downstream transfers.

Function
REQ-012 SHALL hold a 2-entry holding buffer (head, tail), with occupancy count in 0..2 and a 1-bit inflight flag.
- Buffer state: count, inflight, words_out.
- Definitions used below: pop = out_valid & out_ready; land = inflight.
REQ-013 SHALL drive fifo_rd = !fifo_empty & ((count + inflight - pop) < 2), combinationally.
- Consequence: fifo_rd may depend combinationally on out_ready.
REQ-014 SHALL set inflight on the next edge to the value of fifo_rd; only one read is ever outstanding.
REQ-015 SHALL capture ram_rdata into the buffer on each edge where land=1.
- Placement: written to head if the buffer is effectively empty after pop; otherwise written to tail.
REQ-016 SHALL update the buffer on each edge where pop=1.
- Tail shifts to head.
- Simultaneous pop and land: count unchanged; ordering preserved (old tail to head, new word to tail).
REQ-017 SHALL update count on each edge as count_next = count + land - pop; count SHALL never exceed 2 nor underflow.
REQ-018 SHALL drive out_valid = (count != 0) and out_data = head, both registered; there is no combinational path from ram_rdata to the outputs.
REQ-019 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL deliver words in exactly the order in which they were read from the FIFO; no word is dropped or duplicated.
REQ-021 SHALL achieve latency: first out_valid appears 2 cycles after fifo_rd with an empty buffer (read edge, land edge).
REQ-022 SHALL sustain throughput of 1 word/cycle while fifo_empty=0 and out_ready=1.
REQ-023 SHALL increment words_out by 1 on each pop; it wraps modulo 2^CNT_W with no saturation.
REQ-024 SHALL hold fifo_rd=0 while fifo_empty=1; a read already in flight SHALL still land.

Reset
REQ-025 SHALL, while reset=0, asynchronously force count=0, inflight=0, words_out=0, out_valid=0 and out_data=0; fifo_rd SHALL be 0 throughout reset.
REQ-026 SHALL, on a reset asserted mid-operation, discard any in-flight word and buffer contents; the upstream FIFO controller is reset by the same signal.
REQ-027 SHALL make its first possible fifo_rd the first clk edge after reset deasserts, provided fifo_empty=0.

Structure
REQ-028 SHALL take DATA_W and CNT_W defaults from the shared package fifo_pkg.
- Also in fifo_pkg: the buffer depth constant BUF_DEPTH=2 and an occupancy typedef (2-bit).
REQ-029 SHALL be implemented flat, with no sub-modules; the integration top instantiates it beside the FIFO controller and RAM.

Verification
REQ-030 SHALL have a bench that applies: FIFO preloaded with 0x11,0x22,0x33, out_ready=1 -> fifo_rd high 3 consecutive cycles; out_data 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after the first fifo_rd; words_out=3.
REQ-031 SHALL have a bench that applies: 5 words preloaded, out_ready=0 -> exactly 2 reads issued; count=2; out_data holds word 0 stable; fifo_rd stays 0 until out_ready rises.
REQ-032 SHALL have a bench that applies: out_ready toggling 1,0,1,0 with 8 words -> all 8 delivered in order, none duplicated, words_out=8.
REQ-033 SHALL have a bench that applies: fifo_empty=1 throughout -> fifo_rd=0 and out_valid=0 every cycle.
REQ-034 SHALL have a bench that applies: reset=0 asserted the cycle after a fifo_rd -> out_valid=0 immediately (asynchronously), words_out=0, and no stale word appears after release.
REQ-035 SHALL have a bench that applies: words_out preset near wrap (CNT_W=4, 15 transfers then 2 more) -> words_out reads 15 then 0 then 1.
